id_ex_stage: RTL and testbench
==============================

Name: id_ex_stage

Overview:
- ID/EX pipeline register of the scalar pipeline, directly downstream of the control decoder.
- Captures decoded control signals, register operands, immediate and PC. Contains load-use hazard detection, bubble insertion, branch flush and global freeze.
- Drives the EX stage. Drives `stall_o` back to PC/IF-ID.

Parameters:
- DATA_W, 32, operand/immediate width
- REG_AW, 4, register address width (R0 hardwired zero)
- PC_W, 16, program counter width
- CNT_W, 16, bubble performance counter width

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- freeze_i  in  1  global pipeline freeze (memory wait)
- flush_i  in  1  branch taken resolved downstream; squash ID instruction
- id_valid_i  in  1  IF/ID holds a real instruction
- id_ctrl_i  in  12  {RegDst,ALUSrc,MemtoReg,RegWrite,MemRead,MemWrite,Branch,Jump,ALUOperation[3:0]} from decoder
- id_rs_i, id_rt_i, id_rd_i  in  REG_AW  register fields
- id_rdata_a_i, id_rdata_b_i  in  DATA_W  register file read data
- id_imm_i  in  DATA_W  sign-extended immediate
- id_pc_i  in  PC_W  PC+1 of instruction
- ex_valid_o  out  1  EX holds a real instruction
- ex_ctrl_o  out  12  registered control, same packing
- ex_rs_o, ex_rt_o, ex_rd_o  out  REG_AW  registered fields
- ex_rdata_a_o, ex_rdata_b_o, ex_imm_o  out  DATA_W  registered operands
- ex_pc_o  out  PC_W  registered PC
- stall_o  out  1  hold PC and IF/ID this cycle (combinational)
- bubble_cnt_o  out  CNT_W  saturating count of inserted bubbles

Behaviour:
- Reset (async, rst_n=0): every registered output is 0, ex_valid_o=0, bubble_cnt_o=0. stall_o is then driven by freeze_i only. Reset mid-operation discards the in-flight instruction.
- Hazard (combinational, submodule). Condition: ex_valid_o & ex_ctrl_o.MemRead & ex_rt_o!=0 & id_valid_i & (ex_rt_o==id_rs_i | (ex_rt_o==id_rt_i & uses_rt)).
  - uses_rt = !ALUSrc | MemWrite | Branch (ADD, XOR, BEQ, SW).
  - MOV and LW use rs only.
- Per-edge priority, highest first:
  1. freeze_i=1: all EX registers hold; counter holds; stall_o=1.
  2. flush_i=1: load bubble (ex_valid_o=0, ex_ctrl_o=0, data fields 0); stall_o=0; counter +1. Flush overrides a simultaneous hazard.
  3. Hazard=1: load bubble; stall_o=1; counter +1. Next cycle the LW has moved on and the hazard clears, giving exactly one bubble per load-use.
  4. Normal: capture all id_* inputs, ex_valid_o=id_valid_i.
     - If id_valid_i=0, ctrl is forced to 0, so unknown decoder values (BEQ RegDst/MemtoReg) never propagate.
     - Unknown RegDst/MemtoReg on a valid BEQ/SW are captured as 0.
- stall_o = freeze_i | (hazard & !flush_i).
- Latency: 1 cycle ID→EX.
- Bubble counter saturates at 2^CNT_W−1 and does not wrap.
- A bubble never triggers a hazard, because its ex_valid_o is 0.

Decomposition:
- Shared package pipe_pkg contains:
  - Opcode constants: ADD 00001, MOV 00011, XOR 00101, CMP 01011, BEQ 01100, LW 01101, SW 01111.
  - ALUOperation encodings: 0001 add, 0010 xor, 0011 sub/cmp, 1000 pass-B.
  - Control-bundle bit indices and width (12).
- One combinational submodule, hazard_detect. It takes ex MemRead/valid/rt, id rs/rt/valid and uses_rt, and returns hazard.

Test Plan:
- Reset mid-stream: rst_n low for 1 cycle while ex_valid_o=1 → all outputs 0 immediately, before the next clock edge; bubble_cnt_o=0.
- Pass-through: ADD (ctrl=1_0_0_1_0_0_0_0_0001), rs=2, rt=3, rd=4, A=5, B=7 → next cycle ex_* equal inputs, ex_valid_o=1, stall_o=0.
- Load-use: LW rt=3, then ADD rs=3 → stall_o=1 for exactly one cycle, one bubble, bubble_cnt_o=1; ADD appears in EX two cycles after LW.
- No false hazard:
  - LW rt=3 then MOV rs=1, rt=3 → no stall.
  - LW rt=0 then ADD rs=0 → no stall.
- Flush + hazard same cycle: LW rt=5 in EX, ADD rs=5 in ID, flush_i=1 → bubble, stall_o=0, counter +1.
- Freeze: freeze_i=1 for 3 cycles with a valid SW in EX → ex_* unchanged, stall_o=1, counter unchanged. Normal capture resumes after release.

Source files
------------

// File: rtl/pipe_pkg.sv
// Shared pipeline definitions: opcodes, ALU encodings and control-bundle layout.
package pipe_pkg;

   // Instruction opcodes
   localparam logic [4:0] OP_ADD = 5'b00001;
   localparam logic [4:0] OP_MOV = 5'b00011;
   localparam logic [4:0] OP_XOR = 5'b00101;
   localparam logic [4:0] OP_CMP = 5'b01011;
   localparam logic [4:0] OP_BEQ = 5'b01100;
   localparam logic [4:0] OP_LW  = 5'b01101;
   localparam logic [4:0] OP_SW  = 5'b01111;

   // ALUOperation encodings
   localparam logic [3:0] ALU_ADD   = 4'b0001;
   localparam logic [3:0] ALU_XOR   = 4'b0010;
   localparam logic [3:0] ALU_SUB   = 4'b0011;
   localparam logic [3:0] ALU_PASSB = 4'b1000;

   // Control bundle: {RegDst,ALUSrc,MemtoReg,RegWrite,MemRead,MemWrite,Branch,Jump,ALUOperation[3:0]}
   localparam int CTRL_W      = 12;
   localparam int CB_REGDST   = 11;
   localparam int CB_ALUSRC   = 10;
   localparam int CB_MEMTOREG = 9;
   localparam int CB_REGWRITE = 8;
   localparam int CB_MEMREAD  = 7;
   localparam int CB_MEMWRITE = 6;
   localparam int CB_BRANCH   = 5;
   localparam int CB_JUMP     = 4;
   localparam int CB_ALUOP_HI = 3;
   localparam int CB_ALUOP_LO = 0;

   // An instruction reads rt when its second ALU operand is a register, or it stores/compares rt
   function automatic logic uses_rt(input logic [CTRL_W-1:0] c);
      return !c[CB_ALUSRC] | c[CB_MEMWRITE] | c[CB_BRANCH];
   endfunction

   // BEQ/SW leave RegDst and MemtoReg undefined in the decoder; pin them low so nothing downstream sees junk
   function automatic logic [CTRL_W-1:0] sanitize_ctrl(input logic [CTRL_W-1:0] c);
      logic [CTRL_W-1:0] r;
      r = c;
      if (c[CB_BRANCH] | c[CB_MEMWRITE]) begin
         r[CB_REGDST]   = 1'b0;
         r[CB_MEMTOREG] = 1'b0;
      end
      return r;
   endfunction

endpackage

// File: rtl/id_ex_stage_hazard_detect.sv
// Load-use hazard detector: a load in EX whose destination is read by the instruction in ID.
module hazard_detect
   import pipe_pkg::*;
#(
   parameter int REG_AW = 4
) (
   input  logic              ex_valid,
   input  logic              ex_memread,
   input  logic [REG_AW-1:0] ex_rt,
   input  logic              id_valid,
   input  logic [REG_AW-1:0] id_rs,
   input  logic [REG_AW-1:0] id_rt,
   input  logic              id_uses_rt,
   output logic              hazard
);

   // R0 is hardwired zero, so a load into it never creates a dependency
   always_comb begin
      hazard = 1'b0;
      if (ex_valid && ex_memread && (ex_rt != '0) && id_valid) begin
         hazard = (ex_rt == id_rs) || ((ex_rt == id_rt) && id_uses_rt);
      end
   end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use bubble insertion, branch flush, freeze and bubble counter.
module id_ex_stage
   import pipe_pkg::*;
#(
   parameter int DATA_W = 32,
   parameter int REG_AW = 4,
   parameter int PC_W   = 16,
   parameter int CNT_W  = 16
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              freeze_i,
   input  logic              flush_i,
   input  logic              id_valid_i,
   input  logic [CTRL_W-1:0] id_ctrl_i,
   input  logic [REG_AW-1:0] id_rs_i,
   input  logic [REG_AW-1:0] id_rt_i,
   input  logic [REG_AW-1:0] id_rd_i,
   input  logic [DATA_W-1:0] id_rdata_a_i,
   input  logic [DATA_W-1:0] id_rdata_b_i,
   input  logic [DATA_W-1:0] id_imm_i,
   input  logic [PC_W-1:0]   id_pc_i,
   output logic              ex_valid_o,
   output logic [CTRL_W-1:0] ex_ctrl_o,
   output logic [REG_AW-1:0] ex_rs_o,
   output logic [REG_AW-1:0] ex_rt_o,
   output logic [REG_AW-1:0] ex_rd_o,
   output logic [DATA_W-1:0] ex_rdata_a_o,
   output logic [DATA_W-1:0] ex_rdata_b_o,
   output logic [DATA_W-1:0] ex_imm_o,
   output logic [PC_W-1:0]   ex_pc_o,
   output logic              stall_o,
   output logic [CNT_W-1:0]  bubble_cnt_o
);

   logic hazard;
   logic bubble;

   hazard_detect #(
      .REG_AW (REG_AW)
   ) u_hazard (
      .ex_valid   (ex_valid_o),
      .ex_memread (ex_ctrl_o[CB_MEMREAD]),
      .ex_rt      (ex_rt_o),
      .id_valid   (id_valid_i),
      .id_rs      (id_rs_i),
      .id_rt      (id_rt_i),
      .id_uses_rt (uses_rt(id_ctrl_i)),
      .hazard     (hazard)
   );

   // Flush wins over a hazard: the dependent instruction is squashed anyway, so no need to hold IF/ID
   assign stall_o = freeze_i | (hazard & ~flush_i);
   assign bubble  = ~freeze_i & (flush_i | hazard);

   // EX register: hold on freeze, load a bubble on flush/hazard, otherwise capture ID
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ex_valid_o   <= 1'b0;
         ex_ctrl_o    <= '0;
         ex_rs_o      <= '0;
         ex_rt_o      <= '0;
         ex_rd_o      <= '0;
         ex_rdata_a_o <= '0;
         ex_rdata_b_o <= '0;
         ex_imm_o     <= '0;
         ex_pc_o      <= '0;
      end else if (freeze_i) begin
         ex_valid_o   <= ex_valid_o;
      end else if (bubble) begin
         ex_valid_o   <= 1'b0;
         ex_ctrl_o    <= '0;
         ex_rs_o      <= '0;
         ex_rt_o      <= '0;
         ex_rd_o      <= '0;
         ex_rdata_a_o <= '0;
         ex_rdata_b_o <= '0;
         ex_imm_o     <= '0;
         ex_pc_o      <= '0;
      end else begin
         ex_valid_o   <= id_valid_i;
         ex_ctrl_o    <= id_valid_i ? sanitize_ctrl(id_ctrl_i) : '0;
         ex_rs_o      <= id_rs_i;
         ex_rt_o      <= id_rt_i;
         ex_rd_o      <= id_rd_i;
         ex_rdata_a_o <= id_rdata_a_i;
         ex_rdata_b_o <= id_rdata_b_i;
         ex_imm_o     <= id_imm_i;
         ex_pc_o      <= id_pc_i;
      end
   end

   // Bubble counter saturates at all-ones rather than wrapping
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         bubble_cnt_o <= '0;
      end else if (bubble && (bubble_cnt_o != '1)) begin
         bubble_cnt_o <= bubble_cnt_o + 1'b1;
      end
   end

endmodule

// File: tb/tb_id_ex_stage.sv
// Bench for id_ex_stage: directed scenarios then random traffic against an instruction-level model.
module tb_id_ex_stage;

   localparam int DATA_W = 32;
   localparam int REG_AW = 4;
   localparam int PC_W   = 16;
   localparam int CNT_W  = 4;
   localparam int CNT_MAX = (1 << CNT_W) - 1;

   // instruction kinds used by the model
   localparam int K_NONE = 0, K_ADD = 1, K_MOV = 2, K_XOR = 3, K_CMP = 4, K_BEQ = 5, K_LW = 6, K_SW = 7;

   logic              clk = 1'b0;
   logic              rst_n;
   logic              freeze_i, flush_i, id_valid_i;
   logic [11:0]       id_ctrl_i;
   logic [REG_AW-1:0] id_rs_i, id_rt_i, id_rd_i;
   logic [DATA_W-1:0] id_rdata_a_i, id_rdata_b_i, id_imm_i;
   logic [PC_W-1:0]   id_pc_i;
   logic              ex_valid_o, stall_o;
   logic [11:0]       ex_ctrl_o;
   logic [REG_AW-1:0] ex_rs_o, ex_rt_o, ex_rd_o;
   logic [DATA_W-1:0] ex_rdata_a_o, ex_rdata_b_o, ex_imm_o;
   logic [PC_W-1:0]   ex_pc_o;
   logic [CNT_W-1:0]  bubble_cnt_o;

   id_ex_stage #(.DATA_W(DATA_W), .REG_AW(REG_AW), .PC_W(PC_W), .CNT_W(CNT_W)) dut (
      .clk(clk), .rst_n(rst_n), .freeze_i(freeze_i), .flush_i(flush_i),
      .id_valid_i(id_valid_i), .id_ctrl_i(id_ctrl_i),
      .id_rs_i(id_rs_i), .id_rt_i(id_rt_i), .id_rd_i(id_rd_i),
      .id_rdata_a_i(id_rdata_a_i), .id_rdata_b_i(id_rdata_b_i), .id_imm_i(id_imm_i), .id_pc_i(id_pc_i),
      .ex_valid_o(ex_valid_o), .ex_ctrl_o(ex_ctrl_o),
      .ex_rs_o(ex_rs_o), .ex_rt_o(ex_rt_o), .ex_rd_o(ex_rd_o),
      .ex_rdata_a_o(ex_rdata_a_o), .ex_rdata_b_o(ex_rdata_b_o), .ex_imm_o(ex_imm_o), .ex_pc_o(ex_pc_o),
      .stall_o(stall_o), .bubble_cnt_o(bubble_cnt_o)
   );

   always #5 clk = ~clk;

   int passed = 0;
   int total  = 0;

   // model state: what EX should hold
   int          m_kind;
   logic        m_valid;
   logic [11:0] m_ctrl;
   logic [REG_AW-1:0] m_rs, m_rt, m_rd;
   logic [DATA_W-1:0] m_a, m_b, m_imm;
   logic [PC_W-1:0]   m_pc;
   int          m_cnt;
   int          cur_kind;

   // canonical decoded control per instruction kind (undefined fields as 0)
   function automatic logic [11:0] canon(input int k);
      case (k)
         K_ADD:   return 12'b1001_0000_0001;
         K_XOR:   return 12'b1001_0000_0010;
         K_MOV:   return 12'b0101_0000_1000;
         K_CMP:   return 12'b0000_0000_0011;
         K_BEQ:   return 12'b0000_0010_0011;
         K_LW:    return 12'b0111_1000_0001;
         K_SW:    return 12'b0100_0100_0001;
         default: return 12'b0;
      endcase
   endfunction

   function automatic bit reads_rt(input int k);
      return (k == K_ADD) || (k == K_XOR) || (k == K_CMP) || (k == K_BEQ) || (k == K_SW);
   endfunction

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) passed++;
      else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
   endtask

   // dontcare: random junk on the decoder's undefined RegDst/MemtoReg for BEQ/SW
   task automatic drive(input bit frz, input bit fl, input bit vld, input int k,
                        input int rs, input int rt, input int rd,
                        input logic [DATA_W-1:0] a, input logic [DATA_W-1:0] b, input bit junk);
      logic [11:0] c;
      c = canon(k);
      if (junk && (k == K_BEQ || k == K_SW)) c = c | 12'b1010_0000_0000;
      freeze_i = frz; flush_i = fl; id_valid_i = vld; id_ctrl_i = c; cur_kind = k;
      id_rs_i = REG_AW'(rs); id_rt_i = REG_AW'(rt); id_rd_i = REG_AW'(rd);
      id_rdata_a_i = a; id_rdata_b_i = b;
      id_imm_i = $urandom; id_pc_i = PC_W'($urandom);
   endtask

   task automatic check_ex(input string tag);
      chk({tag, ".valid"}, 64'(ex_valid_o), 64'(m_valid));
      chk({tag, ".ctrl"},  64'(ex_ctrl_o),  64'(m_ctrl));
      chk({tag, ".rs"},    64'(ex_rs_o),    64'(m_rs));
      chk({tag, ".rt"},    64'(ex_rt_o),    64'(m_rt));
      chk({tag, ".rd"},    64'(ex_rd_o),    64'(m_rd));
      chk({tag, ".a"},     64'(ex_rdata_a_o), 64'(m_a));
      chk({tag, ".b"},     64'(ex_rdata_b_o), 64'(m_b));
      chk({tag, ".imm"},   64'(ex_imm_o),   64'(m_imm));
      chk({tag, ".pc"},    64'(ex_pc_o),    64'(m_pc));
      chk({tag, ".cnt"},   64'(bubble_cnt_o), 64'(m_cnt));
   endtask

   task automatic model_reset();
      m_kind = K_NONE; m_valid = 0; m_ctrl = 0; m_rs = 0; m_rt = 0; m_rd = 0;
      m_a = 0; m_b = 0; m_imm = 0; m_pc = 0; m_cnt = 0;
   endtask

   // one clock: check stall before the edge, advance the model, check EX after the edge
   task automatic step(input string tag);
      bit haz, bub;
      #1;
      haz = (m_valid && m_kind == K_LW && m_rt != 0 && id_valid_i &&
             (m_rt == id_rs_i || (reads_rt(cur_kind) && m_rt == id_rt_i)));
      chk({tag, ".stall"}, 64'(stall_o), 64'(freeze_i || (haz && !flush_i)));
      @(posedge clk);
      if (!freeze_i) begin
         bub = flush_i || haz;
         if (bub) begin
            m_kind = K_NONE; m_valid = 0; m_ctrl = 0; m_rs = 0; m_rt = 0; m_rd = 0;
            m_a = 0; m_b = 0; m_imm = 0; m_pc = 0;
            if (m_cnt < CNT_MAX) m_cnt++;
         end else begin
            m_valid = id_valid_i;
            m_kind  = id_valid_i ? cur_kind : K_NONE;
            m_ctrl  = id_valid_i ? canon(cur_kind) : 12'b0;
            m_rs = id_rs_i; m_rt = id_rt_i; m_rd = id_rd_i;
            m_a = id_rdata_a_i; m_b = id_rdata_b_i; m_imm = id_imm_i; m_pc = id_pc_i;
         end
      end
      #1;
      check_ex(tag);
   endtask

   initial begin
      int k, r;
      rst_n = 0;
      drive(0, 0, 0, K_NONE, 0, 0, 0, 0, 0, 0);
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      check_ex("reset");
      chk("reset.stall", 64'(stall_o), 64'(0));
      rst_n = 1;

      // pass-through ADD
      drive(0, 0, 1, K_ADD, 2, 3, 4, 5, 7, 0); step("add");

      // load-use: one bubble, then ADD enters EX
      drive(0, 0, 1, K_LW, 1, 3, 0, 9, 0, 0);  step("lu.lw");
      drive(0, 0, 1, K_ADD, 3, 2, 6, 1, 2, 0); step("lu.bub");
      step("lu.add");
      chk("lu.cnt1", 64'(bubble_cnt_o), 64'(1));

      // no false hazards
      drive(0, 0, 1, K_LW, 2, 3, 0, 4, 0, 0);  step("nf.lw3");
      drive(0, 0, 1, K_MOV, 1, 3, 0, 8, 8, 0); step("nf.mov");
      drive(0, 0, 1, K_LW, 2, 0, 0, 4, 0, 0);  step("nf.lw0");
      drive(0, 0, 1, K_ADD, 0, 0, 5, 1, 1, 0); step("nf.add0");

      // flush with simultaneous hazard
      drive(0, 0, 1, K_LW, 1, 5, 0, 3, 0, 0);  step("fh.lw");
      drive(0, 1, 1, K_ADD, 5, 5, 7, 1, 1, 0); step("fh.flush");

      // freeze with a valid SW in EX (junk on undefined fields)
      drive(0, 0, 1, K_SW, 2, 4, 0, 11, 22, 1); step("fz.sw");
      for (int i = 0; i < 3; i++) begin
         drive(1, $urandom_range(0, 1), 1, K_ADD, 1, 2, 3, $urandom, $urandom, 0);
         step("fz.hold");
      end
      drive(0, 0, 1, K_XOR, 6, 7, 8, 13, 14, 0); step("fz.rel");

      // asynchronous reset mid-stream with a valid instruction in EX
      drive(0, 0, 1, K_BEQ, 1, 2, 0, 3, 4, 1); step("rs.beq");
      freeze_i = 1;
      rst_n = 0;
      #1;
      model_reset();
      check_ex("rs.async");
      chk("rs.stall", 64'(stall_o), 64'(1));
      @(posedge clk); #1;
      check_ex("rs.hold");
      rst_n = 1;
      freeze_i = 0;

      // random traffic; small register range makes load-use common, counter saturates
      for (int i = 0; i < 300; i++) begin
         r = $urandom_range(0, 9);
         k = (r < 3) ? K_LW : (1 + (r % 7));
         drive($urandom_range(0, 9) == 0, $urandom_range(0, 9) == 0, $urandom_range(0, 9) != 0, k,
               $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 15),
               $urandom, $urandom, $urandom_range(0, 1));
         step("rnd");
      end
      chk("rnd.sat", 64'(bubble_cnt_o), 64'(m_cnt));

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
